// File: rtl/integrate_dump_8.sv
// Decimate-by-DECIM integrate-and-dump for I/Q: result registered 1 cycle after the DECIM-th accept; in_ready drops only when a finished group would overwrite an unconsumed output.
// Optional macro INTEGRATE_DUMP_ROUND_EN selects round-half-up instead of truncation toward -inf.
module integrate_dump_8 #(
    parameter int DATA_W = 12,
    parameter int DECIM  = 8,
    parameter int CNT_W  = $clog2(DECIM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_i,
    input  logic [DATA_W-1:0] in_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_i,
    output logic [DATA_W-1:0] out_q,
    output logic [CNT_W-1:0]  phase
);

    localparam int ACC_W = DATA_W + CNT_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIM - 1);

    logic [ACC_W-1:0]  r_acc_i;
    logic [ACC_W-1:0]  r_acc_q;
    logic [CNT_W-1:0]  r_phase;
    logic [DATA_W-1:0] r_out_i;
    logic [DATA_W-1:0] r_out_q;
    logic              r_out_valid;

    logic [ACC_W-1:0]  w_ext_i;
    logic [ACC_W-1:0]  w_ext_q;
    logic [ACC_W-1:0]  w_sum_i;
    logic [ACC_W-1:0]  w_sum_q;
    logic [DATA_W-1:0] w_res_i;
    logic [DATA_W-1:0] w_res_q;
    logic              w_last;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_load;

    assign w_ext_i = {{CNT_W{in_i[DATA_W-1]}}, in_i};
    assign w_ext_q = {{CNT_W{in_q[DATA_W-1]}}, in_q};

    // Phase 0 starts a fresh group, so the previous sum is never carried over.
    assign w_sum_i = (r_phase == '0) ? w_ext_i : (r_acc_i + w_ext_i);
    assign w_sum_q = (r_phase == '0) ? w_ext_q : (r_acc_q + w_ext_q);

    assign w_last     = (r_phase == LAST);
    assign w_in_ready = !(w_last && r_out_valid && !out_ready);
    assign w_accept   = in_valid && w_in_ready && !clr;
    assign w_load     = w_accept && w_last;

`ifdef INTEGRATE_DUMP_ROUND_EN
    localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (CNT_W - 1);

    logic [ACC_W:0] w_rnd_i;
    logic [ACC_W:0] w_rnd_q;
    logic           w_unused_rnd;

    // The rounded sum still fits ACC_W signed bits, so the extra top bit is a copy of the sign.
    assign w_rnd_i      = {w_sum_i[ACC_W-1], w_sum_i} + HALF;
    assign w_rnd_q      = {w_sum_q[ACC_W-1], w_sum_q} + HALF;
    assign w_res_i      = w_rnd_i[ACC_W-1:CNT_W];
    assign w_res_q      = w_rnd_q[ACC_W-1:CNT_W];
    assign w_unused_rnd = ^{w_rnd_i[ACC_W], w_rnd_i[CNT_W-1:0], w_rnd_q[ACC_W], w_rnd_q[CNT_W-1:0]};
`else
    assign w_res_i = w_sum_i[ACC_W-1:CNT_W];
    assign w_res_q = w_sum_q[ACC_W-1:CNT_W];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc_i     <= '0;
            r_acc_q     <= '0;
            r_phase     <= '0;
            r_out_i     <= '0;
            r_out_q     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (clr) begin
                r_phase <= '0;
                r_acc_i <= '0;
                r_acc_q <= '0;
            end else if (w_accept) begin
                r_phase <= r_phase + CNT_W'(1);
                r_acc_i <= w_sum_i;
                r_acc_q <= w_sum_q;
            end

            // A fresh result replaces a departing one in the same cycle without a bubble.
            if (w_load) begin
                r_out_i     <= w_res_i;
                r_out_q     <= w_res_q;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_i     = r_out_i;
    assign out_q     = r_out_q;
    assign phase     = r_phase;

endmodule

// File: tb/tb_integrate_dump_8.sv
// Randomized bench for integrate_dump_8 with a queue-based reference model and output scoreboard.
module tb_integrate_dump_8;

    localparam int DATA_W = 12;
    localparam int DECIM  = 8;
    localparam int CNT_W  = $clog2(DECIM);

    logic              clk;
    logic              rst;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_i;
    logic [DATA_W-1:0] in_q;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_i;
    logic [DATA_W-1:0] out_q;
    logic [CNT_W-1:0]  phase;

    integrate_dump_8 #(.DATA_W(DATA_W), .DECIM(DECIM), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
        .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_i[$];
    int exp_q[$];
    int m_cnt = 0;
    int m_si  = 0;
    int m_sq  = 0;
    bit rnd_on = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int floor_div(input int s);
        if (s >= 0) return s / DECIM;
        return -((-s + DECIM - 1) / DECIM);
    endfunction

    function automatic int average(input int s);
`ifdef INTEGRATE_DUMP_ROUND_EN
        return floor_div(s + DECIM / 2);
`else
        return floor_div(s);
`endif
    endfunction

    // Monitor + reference model: everything observed mid-cycle, before the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            exp_i.delete();
            exp_q.delete();
            m_cnt = 0;
            m_si  = 0;
            m_sq  = 0;
        end else begin
            chk("out_valid", int'(out_valid), int'(exp_i.size() != 0));
            chk("phase", int'(phase), m_cnt);
            chk("in_ready", int'(in_ready),
                int'(!(m_cnt == DECIM - 1 && exp_i.size() != 0 && !out_ready)));
            if (out_valid && exp_i.size() != 0) begin
                chk("out_i", int'($signed(out_i)), exp_i[0]);
                chk("out_q", int'($signed(out_q)), exp_q[0]);
                if (out_ready) begin
                    void'(exp_i.pop_front());
                    void'(exp_q.pop_front());
                end
            end
            if (clr) begin
                m_cnt = 0;
                m_si  = 0;
                m_sq  = 0;
            end else if (in_valid && in_ready) begin
                m_si += int'($signed(in_i));
                m_sq += int'($signed(in_q));
                m_cnt++;
                if (m_cnt == DECIM) begin
                    exp_i.push_back(average(m_si));
                    exp_q.push_back(average(m_sq));
                    m_cnt = 0;
                    m_si  = 0;
                    m_sq  = 0;
                end
            end
        end
    end

    task automatic send(input int vi, input int vq);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        in_valid = 1'b1;
        in_i     = DATA_W'(vi);
        in_q     = DATA_W'(vq);
        while (!done) begin
            @(negedge clk);
            done = in_ready && !clr;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 200) begin
                chk("send_timeout", 0, 1);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; clr = 1'b0; in_valid = 1'b0;
        in_i = '0; in_q = '0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_out_i", int'(out_i), 0);
        chk("rst_out_q", int'(out_q), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b1;

        // Constant group.
        for (int k = 0; k < DECIM; k++) send(100, -100);
        @(negedge clk);
        chk("const_valid", int'(out_valid), 1);
        chk("const_i", int'($signed(out_i)), 100);
        chk("const_q", int'($signed(out_q)), -100);
        @(posedge clk); #1;

        // Rounding-sensitive group.
        for (int k = 0; k < DECIM; k++)
            send((k == 0) ? 1 : ((k == DECIM - 1) ? 3 : 0), (k == 0) ? -5 : 0);
        @(negedge clk);
`ifdef INTEGRATE_DUMP_ROUND_EN
        chk("round_i", int'($signed(out_i)), 1);
`else
        chk("trunc_i", int'($signed(out_i)), 0);
`endif
        chk("round_q", int'($signed(out_q)), -1);
        @(posedge clk); #1;

        // Extremes.
        for (int k = 0; k < DECIM; k++) send(2047, -2048);
        @(negedge clk);
        chk("max_i", int'($signed(out_i)), 2047);
        chk("min_q", int'($signed(out_q)), -2048);
        @(posedge clk); #1;
        for (int k = 0; k < DECIM; k++) send(-2048, 2047);
        @(negedge clk);
        chk("min_i", int'($signed(out_i)), -2048);
        @(posedge clk); #1;

        // Backpressure: group 2 completes exactly as group 1 leaves.
        out_ready = 1'b0;
        for (int k = 0; k < DECIM; k++) send(300, -7);
        for (int k = 0; k < DECIM - 1; k++) send(-50, 60);
        fork
            send(-50, 60);
            begin
                repeat (4) @(negedge clk);
                chk("bp_stall", int'(in_ready), 0);
                chk("bp_hold_i", int'($signed(out_i)), 300);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        @(negedge clk);
        chk("bp_no_bubble", int'(out_valid), 1);
        chk("bp_group2_i", int'($signed(out_i)), -50);
        @(posedge clk); #1;

        // Clear mid-group drops the presented sample and the partial sum.
        for (int k = 0; k < 5; k++) send(int'($urandom_range(0, 4095)) - 2048, 1000);
        clr = 1'b1; in_valid = 1'b1; in_i = DATA_W'(999); in_q = DATA_W'(999);
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("clr_phase", int'(phase), 0);
        @(posedge clk); #1;
        for (int k = 0; k < DECIM; k++) send(8, 8);
        @(negedge clk);
        chk("clr_out_i", int'($signed(out_i)), 8);
        @(posedge clk); #1;

        // Randomized traffic with random backpressure and gaps.
        rnd_on = 1;
        fork
            begin
                for (int k = 0; k < 320; k++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048);
                end
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("drain_empty", exp_i.size(), 0);

        // Asynchronous reset mid-group with a pending output.
        out_ready = 1'b0;
        for (int k = 0; k < DECIM; k++) send(5, 5);
        for (int k = 0; k < 3; k++) send(9, 9);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_phase", int'(phase), 0);
        chk("arst_out_i", int'(out_i), 0);
        chk("arst_out_q", int'(out_q), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < DECIM; k++) send(-16, 24);
        @(negedge clk);
        chk("post_rst_i", int'($signed(out_i)), -16);
        chk("post_rst_q", int'($signed(out_q)), 24);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
